stack_controller: RTL
=====================

STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 Parameter DATA_W, 8, width of each stack entry and of the memory data bus.
REQ-002 Parameter ADDR_W, 7, memory address width; TOP_ADDR = 2^ADDR_W-1 (0x7F at default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 op_valid  in  1  one-cycle command strobe.
REQ-006 op  in  3  command: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 CLEAR, 5 TOP, 6 DISP_INC, 7 DISP_DEC.
REQ-007 operand  in  DATA_W  PUSH value, sampled on the accept edge.
REQ-008 mem_cs, mem_we  out  1 each  memory select and write enable.
REQ-009 mem_addr  out  ADDR_W  memory address.
REQ-010 mem_wdata  out  DATA_W  memory write data.
REQ-011 mem_rdata  in  DATA_W  memory read data; memory samples addr/we on falling clk, so rdata is valid at the next rising edge.
REQ-012 busy  out  1  high while a command is executing.
REQ-013 disp_addr  out  ADDR_W  displayed entry address (DAR).
REQ-014 disp_data  out  DATA_W  displayed entry value (DVR).
REQ-015 empty  out  1  stack holds no entries.
REQ-016 full  out  1  stack holds TOP_ADDR entries.
REQ-017 error  out  1  last accepted command was rejected.

Function
REQ-018 SP points to the next free location; the stack grows downward; entries occupy SP+1..TOP_ADDR; empty = (SP==TOP_ADDR); full = (SP==0).
REQ-019 A command is accepted on a rising edge with op_valid=1 and state IDLE; op_valid while busy is ignored without effect.
REQ-020 busy is 0 in IDLE and 1 in every other state.
REQ-021 mem_cs/mem_we/mem_addr/mem_wdata are combinational decodes of state; mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0 in IDLE.
REQ-022 States: IDLE, WR, POP, RDA, RDB, DRD.
REQ-023 A read state drives mem_cs=1, mem_we=0, addr; the controller captures mem_rdata on the edge leaving that state.
REQ-024 PUSH: full -> error=1, stay IDLE; else WR (mem[SP]=operand, SP<=SP-1, DAR<=SP) -> DRD -> IDLE; busy for 2 cycles.
REQ-025 POP: empty -> error=1; else POP (SP<=SP+1, DAR<=SP+2) -> DRD; if the stack becomes empty, skip DRD, DAR<=TOP_ADDR, DVR<=0.
REQ-026 ADD/SUB: fewer than 2 entries -> error=1, no change; else RDA (A=mem[SP+1], SP<=SP+1) -> RDB (B=mem[SP+1], SP<=SP+1) -> WR (mem[SP]=result, SP<=SP-1, DAR<=SP) -> DRD; busy for 4 cycles.
REQ-027 ADD result = B+A; SUB result = B-A (second minus top); both mod 2^DATA_W, no carry or borrow flag.
REQ-028 CLEAR: SP<=TOP_ADDR, DAR<=TOP_ADDR, DVR<=0, no memory access; busy stays 0.
REQ-029 TOP: empty -> no change; else DAR<=SP+1 -> DRD.
REQ-030 DISP_INC: DAR<=DAR+1; from TOP_ADDR it wraps to SP+1; then DRD.
REQ-031 DISP_DEC: DAR<=DAR-1; from SP+1 it wraps to TOP_ADDR; then DRD.
REQ-032 DISP_INC/DISP_DEC when empty: no change, no error.
REQ-033 DRD: read mem[DAR], DVR<=mem_rdata, then IDLE.
REQ-034 error is set or cleared on every accepted command: 1 if the command was rejected, else 0.
REQ-035 A rejected command never writes memory and never changes SP, DAR or DVR.

Reset
REQ-036 rst=1 at a rising edge forces state=IDLE, SP=TOP_ADDR, DAR=TOP_ADDR, DVR=0, error=0; rst has priority over op_valid.
REQ-037 Reset mid-command abandons the command; a WR state active in the reset cycle completes its memory write; no further accesses follow.

Verification
REQ-038 Reset, then PUSH 0x12 and PUSH 0x34 -> mem[0x7F]=0x12, mem[0x7E]=0x34, SP=0x7D, disp_addr=0x7E, disp_data=0x34, empty=0.
REQ-039 Stack 0x05 then 0x03 (top), SUB -> disp_data=0x02, SP=0x7E; repeat with top 0x07 -> disp_data=0xFE; ADD of 0xFF and 0x02 -> disp_data=0x01.
REQ-040 POP on empty and ADD with one entry -> error=1, SP and memory unchanged; a following valid PUSH -> error=0.
REQ-041 Push 127 entries -> full=1; PUSH -> error=1; POP -> full=0, SP=0x01.
REQ-042 Three entries, DISP_INC from 0x7F -> disp_addr=0x7D; DISP_DEC from 0x7D -> disp_addr=0x7F; op_valid pulses during busy have no effect.
REQ-043 rst asserted during RDB of ADD -> next cycle IDLE, SP=0x7F, disp_data=0, mem_we=0.

Source files
------------

// File: rtl/stack_controller.sv
// Stack controller: a downward-growing stack held in an external
// synchronous memory, with arithmetic (ADD/SUB) on the top two entries
// and a display pointer that can walk the live entries.
module stack_controller #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] operand,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              empty,
    output logic              full,
    output logic              error
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};

    localparam logic [2:0] OP_PUSH     = 3'd0;
    localparam logic [2:0] OP_POP      = 3'd1;
    localparam logic [2:0] OP_ADD      = 3'd2;
    localparam logic [2:0] OP_SUB      = 3'd3;
    localparam logic [2:0] OP_CLEAR    = 3'd4;
    localparam logic [2:0] OP_TOP      = 3'd5;
    localparam logic [2:0] OP_DISP_INC = 3'd6;
    localparam logic [2:0] OP_DISP_DEC = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_POP  = 3'd2,
        S_RDA  = 3'd3,
        S_RDB  = 3'd4,
        S_DRD  = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] r_dar;
    logic [DATA_W-1:0] r_dvr;
    logic              r_error;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_operand;
    logic              r_arith;
    logic              r_sub;

    logic              w_empty;
    logic              w_full;
    logic              w_lt2;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [ADDR_W-1:0] w_sp_dec;
    logic [ADDR_W-1:0] w_sp_inc2;
    logic [DATA_W-1:0] w_result;

    // Stack occupancy and pointer arithmetic shared by several states
    assign w_empty   = (r_sp == TOP_ADDR);
    assign w_full    = (r_sp == '0);
    assign w_lt2     = (r_sp >= TOP_ADDR - ADDR_W'(1));
    assign w_sp_inc  = r_sp + ADDR_W'(1);
    assign w_sp_dec  = r_sp - ADDR_W'(1);
    assign w_sp_inc2 = r_sp + ADDR_W'(2);
    assign w_result  = r_sub ? (r_b - r_a) : (r_b + r_a);

    assign busy      = (r_state != S_IDLE);
    assign empty     = w_empty;
    assign full      = w_full;
    assign error     = r_error;
    assign disp_addr = r_dar;
    assign disp_data = r_dvr;

    // Memory port is a pure decode of the current state
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_sp;
                mem_wdata = r_arith ? w_result : r_operand;
            end
            S_RDA, S_RDB: begin
                mem_cs   = 1'b1;
                mem_addr = w_sp_inc;
            end
            S_DRD: begin
                mem_cs   = 1'b1;
                mem_addr = r_dar;
            end
            default: ;
        endcase
    end

    // Command FSM: accept in IDLE, sequence memory accesses, update SP/DAR/DVR
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sp      <= TOP_ADDR;
            r_dar     <= TOP_ADDR;
            r_dvr     <= '0;
            r_error   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_operand <= '0;
            r_arith   <= 1'b0;
            r_sub     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_PUSH: begin
                                if (w_full) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_error   <= 1'b0;
                                    r_operand <= operand;
                                    r_arith   <= 1'b0;
                                    r_state   <= S_WR;
                                end
                            end
                            OP_POP: begin
                                if (w_empty) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_error <= 1'b0;
                                    r_state <= S_POP;
                                end
                            end
                            OP_ADD, OP_SUB: begin
                                if (w_lt2) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_error <= 1'b0;
                                    r_arith <= 1'b1;
                                    r_sub   <= (op == OP_SUB);
                                    r_state <= S_RDA;
                                end
                            end
                            OP_CLEAR: begin
                                r_error <= 1'b0;
                                r_sp    <= TOP_ADDR;
                                r_dar   <= TOP_ADDR;
                                r_dvr   <= '0;
                            end
                            OP_TOP: begin
                                r_error <= 1'b0;
                                if (!w_empty) begin
                                    r_dar   <= w_sp_inc;
                                    r_state <= S_DRD;
                                end
                            end
                            OP_DISP_INC: begin
                                r_error <= 1'b0;
                                if (!w_empty) begin
                                    r_dar   <= (r_dar == TOP_ADDR) ? w_sp_inc : r_dar + ADDR_W'(1);
                                    r_state <= S_DRD;
                                end
                            end
                            OP_DISP_DEC: begin
                                r_error <= 1'b0;
                                if (!w_empty) begin
                                    r_dar   <= (r_dar == w_sp_inc) ? TOP_ADDR : r_dar - ADDR_W'(1);
                                    r_state <= S_DRD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_WR: begin
                    r_sp    <= w_sp_dec;
                    r_dar   <= r_sp;
                    r_state <= S_DRD;
                end
                S_POP: begin
                    r_sp <= w_sp_inc;
                    // Popping the last entry leaves nothing to display
                    if (w_sp_inc == TOP_ADDR) begin
                        r_dar   <= TOP_ADDR;
                        r_dvr   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_dar   <= w_sp_inc2;
                        r_state <= S_DRD;
                    end
                end
                S_RDA: begin
                    r_a     <= mem_rdata;
                    r_sp    <= w_sp_inc;
                    r_state <= S_RDB;
                end
                S_RDB: begin
                    r_b     <= mem_rdata;
                    r_sp    <= w_sp_inc;
                    r_state <= S_WR;
                end
                S_DRD: begin
                    r_dvr   <= mem_rdata;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
